// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and data requesters.
// Data wins by default; a starvation counter forces an inst grant after STARVE_LIMIT data grants.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,

    output logic [3:0]          starve_cnt
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [3:0]  LIMIT  = 4'(STARVE_LIMIT);

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    logic       grant_inst;
    logic       grant_data;
    logic       starved;
    logic       resp_valid;
    logic       resp_owner;
    logic       resp_is_wr;
    logic [3:0] starve_q;

    // Grant decision; suppressed while reset is asserted so nothing reaches the SRAM.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        starved    = (starve_q == LIMIT);
        if (resetn) begin
            if (data_req && !(inst_req && starved)) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // SRAM port drive; unused fields are forced to zero rather than left floating.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_data) begin
            sram_en   = 1'b1;
            sram_addr = data_addr;
            if (data_wr) begin
                sram_we    = data_wstrb;
                sram_wdata = data_wdata;
            end
        end else if (grant_inst) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end
    end

    // Tracks who owns the word coming back from the SRAM next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_owner <= OWNER_INST;
            resp_is_wr <= 1'b0;
        end else begin
            resp_valid <= grant_inst | grant_data;
            if (grant_data) begin
                resp_owner <= OWNER_DATA;
                resp_is_wr <= data_wr;
            end else if (grant_inst) begin
                resp_owner <= OWNER_INST;
                resp_is_wr <= 1'b0;
            end
        end
    end

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= 4'd0;
        end else if (grant_data && inst_req) begin
            if (starve_q != LIMIT) begin
                starve_q <= starve_q + 4'd1;
            end
        end else begin
            starve_q <= 4'd0;
        end
    end

    assign starve_cnt   = starve_q;
    assign inst_data_ok = resp_valid && (resp_owner == OWNER_INST);
    assign data_data_ok = resp_valid && (resp_owner == OWNER_DATA);
    assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
    assign data_rdata   = (data_data_ok && !resp_is_wr) ? sram_rdata : '0;

    logic unused_strb_w;
    assign unused_strb_w = (STRB_W == 0);

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the instruction-fetch requester and the data-access requester of the 5-stage core.
- Lets the core run from a unified memory instead of separate inst/data SRAMs.
- Uses a req/addr_ok/data_ok handshake towards each requester.
- Uses fixed data-over-inst priority with a starvation guard, and routes each returned word to the requester that issued it.

Parameters:
- ADDR_W, 32, address width passed through to the SRAM unchanged.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, number of consecutive data grants allowed while inst_req is waiting. Legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid this cycle.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  data request.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  DATA_W/8  byte enables for a write.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data access complete; read data valid.
- data_rdata  out  DATA_W  read data.
- sram_en  out  1  SRAM enable.
- sram_we  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en.
- starve_cnt  out  4  current starvation counter (debug).

Behaviour:
- Reset is asynchronous, active-low; the following registers clear immediately: resp_valid = 0, resp_owner = 0 (inst), resp_is_wr = 0, starve_cnt = 0.
- While in reset, all outputs are 0: addr_ok, data_ok, sram_en, sram_we, rdata.
- Grant is combinational, evaluated every cycle; at most one grant per cycle:
  - Only inst_req high: grant inst.
  - Only data_req high: grant data.
  - Both high and starve_cnt == STARVE_LIMIT: grant inst.
  - Both high otherwise: grant data.
- The granted requester's addr_ok is 1 in the same cycle; the other requester's addr_ok is 0.
- SRAM drive:
  - Granted request drives sram_en = 1 and sram_addr = its address.
  - For a data write: sram_we = data_wstrb and sram_wdata = data_wdata.
  - For any read: sram_we = 0 and sram_wdata = 0.
  - No grant: sram_en = 0, sram_we = 0, sram_addr and sram_wdata = 0.
- Response register: on a grant, resp_valid <= 1, resp_owner <= granted side, resp_is_wr <= (data grant & data_wr). With no grant, resp_valid <= 0.
- Latency is exactly 1 cycle: the owner's data_ok = resp_valid & (resp_owner matches), in the cycle after addr_ok.
  - inst_rdata = sram_rdata when inst_data_ok, else 0.
  - data_rdata = sram_rdata when data_data_ok and the access was a read, else 0.
  - A write still raises data_data_ok, with data_rdata = 0.
- Back-to-back throughput is one request per cycle. Requesters always accept data_ok; there is no backpressure and no buffering.
- starve_cnt update, each cycle:
  - Data granted while inst_req = 1: increment, saturating at STARVE_LIMIT.
  - Inst granted, or inst_req = 0: clear to 0.
- Requests are level-sensitive. A request that is not granted must be held stable by the requester until addr_ok; the arbiter does not latch ungranted addresses.
- A write with data_wstrb = 0 is still granted and acknowledged, with sram_we = 0 (a no-op write).
- Reset asserted while a response is pending drops that response: no data_ok after reset release.

Test Plan:
1. inst_req only, addr 0x1c000000, SRAM word 0x02800421 → inst_addr_ok in cycle N; inst_data_ok = 1 with inst_rdata = 0x02800421 in cycle N+1; data_data_ok stays 0.
2. Same cycle: data_req read 0x100 and inst_req 0x1c000004 → data granted first; inst granted the next cycle; data_data_ok and inst_data_ok in consecutive cycles with the correct words.
3. data_req write to 0x200, wstrb 0xF, wdata 0xDEADBEEF, then a read of 0x200 the next cycle → sram_we = 0xF in cycle 1; write data_ok with rdata 0 in cycle 2; read returns 0xDEADBEEF in cycle 3.
4. Starvation, STARVE_LIMIT = 4, data_req and inst_req both held high for 10 cycles → grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt climbs 1,2,3,4 and then clears to 0.
5. Byte write, wstrb 0x3, wdata 0x0000ABCD, onto a location holding 0x11111111 → a readback returns 0x1111ABCD; sram_we = 0x3 only in the write cycle.
6. resetn pulled low for 1 cycle, asynchronously, the cycle after an inst grant → inst_data_ok never asserts; all outputs are 0 during reset; starve_cnt = 0; a normal fetch works after release.
